// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and segment/digit constants for the 4-digit scan controller
package seg_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, BLANK} state_e;
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [3:0] DIG_OFF  = 4'hF;
endpackage

// File: rtl/seg7_dec.sv
// seg7_dec: BCD nibble to active-high a..g segments; non-decimal nibbles show a dash
module seg7_dec
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  always_comb begin
    case (nib_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 4-digit 7-segment scanner with frame-synchronous value updates.
// Define SEG_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_DIV  = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        clk1k,
  input  logic        rst_n,
  input  logic        en,
  input  logic        upd_valid,
  input  logic [15:0] upd_data,
  output logic        upd_ready,
  output logic [6:0]  seg,
  output logic [3:0]  dig,
  output logic        frame_end
);
  localparam logic [7:0] DRIVE_LAST = 8'(SCAN_DIV - 1);
  localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYC - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic [6:0]  seg_q, seg_d, dec_seg;
  logic [3:0]  dig_q, dig_d, nib;
  logic        fe_q, fe_d, take, load, shown;

  always_ff @(posedge clk1k or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 8'd1;
    if (!en || (state_q != DRIVE && state_q != BLANK)) begin
      state_d = en ? DRIVE : IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == DRIVE && cnt_q == DRIVE_LAST) begin
      state_d = BLANK;
      cnt_d   = '0;
    end else if (state_q == BLANK && cnt_q == BLANK_LAST) begin
      state_d = DRIVE;
      idx_d   = idx_q + 2'd1;
      cnt_d   = '0;
    end
  end

  // Pending value only reaches the display at a frame boundary or while idle.
  assign take       = upd_valid & ~pend_vld_q;
  assign load       = (state_q == IDLE || fe_q) && pend_vld_q;
  assign pend_d     = take ? upd_data : pend_q;
  assign pend_vld_d = take | (pend_vld_q & ~load);
  assign disp_d     = load ? pend_q : disp_q;
  assign nib        = 4'(disp_d >> {idx_d, 2'b00});

  seg7_dec u_dec (.nib_i(nib), .seg_o(dec_seg));

`ifdef SEG_LZ_BLANK_EN
  logic [3:0] lz;
  assign lz[3] = disp_d[15:12] == 4'd0;
  assign lz[2] = lz[3] & (disp_d[11:8] == 4'd0);
  assign lz[1] = lz[2] & (disp_d[7:4] == 4'd0);
  assign lz[0] = 1'b0;
  assign shown = ~lz[idx_d];
`else
  assign shown = 1'b1;
`endif

  // Outputs are computed from next state so the registered values line up with state_q.
  always_comb begin
    dig_d = (state_d == DRIVE) ? ~(4'b0001 << idx_d) : DIG_OFF;
    seg_d = (state_d == DRIVE && shown) ? dec_seg : SEG_OFF;
    fe_d  = state_d == BLANK && idx_d == 2'd3 && cnt_d == BLANK_LAST;
  end

  always_ff @(posedge clk1k or negedge rst_n) begin
    if (!rst_n) begin
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      dig_q      <= DIG_OFF;
      fe_q       <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      seg_q      <= seg_d;
      dig_q      <= dig_d;
      fe_q       <= fe_d;
    end
  end

  assign upd_ready = ~pend_vld_q;
  assign seg       = seg_q;
  assign dig       = dig_q;
  assign frame_end = fe_q;
endmodule
